div_request_sequencer: RTL and testbench
========================================

# div_request_sequencer

Front-end sequencer for the repeated-subtraction divider core. It accepts operand pairs over a valid/ready handshake and re-initialises the divider core before every operation. It drives the core's start input, waits for `done`, and returns the quotient and remainder over a second valid/ready handshake. Divide-by-zero is handled locally without launching the core, and a watchdog bounds how long it waits on a core that never finishes.

## Interface
- `WIDTH`, 16: operand, quotient and remainder width.
- `TIMEOUT`, 2**WIDTH+8: number of WAIT cycles without `div_done` before the operation is aborted. Counter width is clog2(TIMEOUT+1).
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: an operand pair is offered.
- `in_ready` output 1: the block can accept an operand pair.
- `in_dividend` input WIDTH: dividend.
- `in_divisor` input WIDTH: divisor.
- `op_a` output WIDTH: registered dividend driven to the core datapath.
- `op_b` output WIDTH: registered divisor driven to the core datapath.
- `div_rst` output 1: reset to the divider core.
- `div_start` output 1: start pulse to the divider controller.
- `div_done` input 1: core has finished. It is sticky until the core is reset.
- `div_quotient` input WIDTH: quotient from the core.
- `div_remainder` input WIDTH: remainder from the core.
- `out_valid` output 1: result is available.
- `out_ready` input 1: the consumer accepts the result.
- `out_quotient` output WIDTH: captured quotient.
- `out_remainder` output WIDTH: captured remainder.
- `out_dz` output 1: the result is a divide-by-zero result.
- `out_err` output 1: the result is a watchdog abort.
- `busy` output 1: the state is anything other than IDLE.

## Operation
- All outputs are registered or decoded from state only. No combinational path runs from inputs to outputs.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid`: capture the operands into `op_a`/`op_b` and clear `out_dz`/`out_err`.
  - If `in_divisor==0`, go to OUT with `out_quotient` = all ones, `out_remainder=in_dividend` and `out_dz=1`.
  - Otherwise go to CLEAR.
- **CLEAR** (1 cycle)
  - `div_rst=1`. This forces the core back to its initial state and drops any stale sticky `div_done`.
  - Go to START.
- **START** (1 cycle)
  - `div_start=1` and `div_rst=0`.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - `div_start=0`. The watchdog increments each cycle.
  - If `div_done==1`: capture `div_quotient`/`div_remainder` into the outputs and go to OUT. `div_done` takes priority over a watchdog expiry in the same cycle.
  - Else if the counter reaches `TIMEOUT-1`: set `out_err=1` and `out_quotient=out_remainder=0`, then go to OUT.
- **OUT**
  - `out_valid=1`. All output data is held stable.
  - On `out_ready`, go to IDLE.
  - `op_a`/`op_b` hold their last values until the next accept.
- `div_done` is ignored in every state except WAIT.
- `in_valid` is ignored while `in_ready=0`. Exactly one operation is in flight at a time.
- Results are passed through unmodified. This block does not check the core's arithmetic.

## Timing
- **Reset values**
  - State = IDLE.
  - `in_ready=1`, `div_rst=1`. `div_rst` is held for as long as `rst` is high.
  - `div_start=0`, `out_valid=0`, `out_dz=0`, `out_err=0`, `busy=0`.
  - `op_a`, `op_b`, `out_quotient` and `out_remainder` are 0.
- **Accept to `div_start`:** accept at edge N. `div_rst` is high during cycle N+1 and `div_start` is high during cycle N+2. WAIT begins at N+3.
- **Done to `out_valid`:** `div_done` is sampled high at edge M and `out_valid` is high from M onward. Total latency is core latency + 3 cycles of overhead + 1.
- **Divide-by-zero:** accept at edge N, `out_valid` high at N. The core is never started.
- **Watchdog:** `out_valid` with `out_err` is asserted exactly `TIMEOUT` cycles after entering WAIT.
- **Back-to-back:** `out_valid && out_ready` at edge K returns to IDLE, and `in_ready` is high after K. The next accept is possible at edge K+1, so there are no zero-bubble transfers.
- **Reset mid-operation:** asserting `rst` in any state immediately forces the reset values. Any captured result is discarded and `out_valid` drops without a handshake.

## Test plan
- **Normal division:** 100/7 with `out_ready=1` and a behavioural core model -> one `div_rst` pulse, then one `div_start` pulse. Result: `out_quotient=14`, `out_remainder=2`, `out_dz=0`, `out_err=0`.
- **Dividend smaller than divisor:** 3/10 -> `out_quotient=0`, `out_remainder=3`. Then 65535/1 -> `out_quotient=65535`, `out_remainder=0`.
- **Divide-by-zero:** 5/0 -> `div_rst` and `div_start` never toggle. `out_valid` is asserted one cycle after the accept, with `out_quotient=16'hFFFF`, `out_remainder=5`, `out_dz=1`.
- **Backpressure:** 50/5 with `out_ready=0` for 10 cycles -> `out_valid` and `out_quotient=10` stay stable and `in_ready` stays 0. `in_valid` is held high throughout and must not be accepted until after the handshake.
- **Watchdog:** `TIMEOUT=20` with a core model that never asserts `div_done` -> `out_err=1` and zero data exactly 20 cycles after WAIT entry. The next operation, 9/3, completes normally with q=3, r=0.
- **Reset mid-WAIT:** pulse `rst` 2 cycles into WAIT -> `div_rst=1` and all outputs return to their reset values asynchronously. A subsequent 20/6 gives q=3, r=2. A stale `div_done` left high from earlier must not cause an early capture.

Source files
------------

// File: rtl/div_request_sequencer.sv
// Front-end sequencer for the repeated-subtraction divider: operand handshake,
// core reset/start sequencing, divide-by-zero bypass and a WAIT watchdog.
module div_request_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 2**WIDTH + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             div_rst,
    output logic             div_start,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_dz,
    output logic             out_err,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_WAIT, S_OUT} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_wdog;
    logic             r_div_rst, r_div_start;
    logic [WIDTH-1:0] r_op_a, r_op_b, r_q, r_r;
    logic             r_dz, r_err;
    logic             w_zero, w_expire;

    assign w_zero   = (in_divisor == '0);
    assign w_expire = (r_wdog == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_zero ? S_OUT : S_CLEAR;
            S_CLEAR: w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (div_done || w_expire) w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Core controls are registered from the next state so they line up with CLEAR/START
    // and the core stays in reset while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_rst   <= 1'b1;
            r_div_start <= 1'b0;
        end else begin
            r_div_rst   <= (w_next == S_CLEAR);
            r_div_start <= (w_next == S_START);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_dz   <= 1'b0;
            r_err  <= 1'b0;
            r_wdog <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op_a <= in_dividend;
                    r_op_b <= in_divisor;
                    r_dz   <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_zero) begin
                        r_q  <= '1;
                        r_r  <= in_dividend;
                        r_dz <= 1'b1;
                    end
                end
                S_START: r_wdog <= '0;
                // done wins over a simultaneous watchdog expiry
                S_WAIT: begin
                    if (div_done) begin
                        r_q <= div_quotient;
                        r_r <= div_remainder;
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                        r_q   <= '0;
                        r_r   <= '0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_OUT);
    assign busy          = (r_state != S_IDLE);
    assign div_rst       = r_div_rst;
    assign div_start     = r_div_start;
    assign op_a          = r_op_a;
    assign op_b          = r_op_b;
    assign out_quotient  = r_q;
    assign out_remainder = r_r;
    assign out_dz        = r_dz;
    assign out_err       = r_err;
endmodule

// File: tb/tb_div_request_sequencer.sv
// Directed bench for div_request_sequencer with a behavioural divider core and a result scoreboard.
module tb_div_request_sequencer;
    localparam int W   = 16;
    localparam int TO  = 20;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_dividend = '0, in_divisor = '0;
    logic         in_ready, div_rst, div_start, div_done, out_valid, out_dz, out_err, busy;
    logic [W-1:0] op_a, op_b, div_quotient, div_remainder, out_quotient, out_remainder;

    always #5 clk = ~clk;

    div_request_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .op_a(op_a), .op_b(op_b),
        .div_rst(div_rst), .div_start(div_start), .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dz(out_dz), .out_err(out_err), .busy(busy)
    );

    // behavioural core: sticky done, cleared only by div_rst
    logic         hang = 1'b0, stale_req = 1'b0;
    logic         c_busy = 1'b0, c_done = 1'b0;
    int           c_cnt = 0;
    logic [W-1:0] c_q = '0, c_r = '0;

    always @(posedge clk) begin
        if (div_rst) begin
            c_busy <= 1'b0; c_done <= 1'b0; c_q <= '0; c_r <= '0; c_cnt <= 0;
        end else if (stale_req) begin
            c_done <= 1'b1; c_q <= 16'hDEAD; c_r <= 16'hBEEF;
        end else if (div_start && !hang) begin
            c_busy <= 1'b1; c_cnt <= LAT;
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                c_busy <= 1'b0; c_done <= 1'b1; c_q <= op_a / op_b; c_r <= op_a % op_b;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end
    end
    assign div_done      = c_done;
    assign div_quotient  = c_q;
    assign div_remainder = c_r;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   n_rst = 0, n_start = 0;

    always @(negedge clk) begin
        if (rst === 1'b0 && div_rst === 1'b1) n_rst++;
        if (div_start === 1'b1) n_start++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dz, input logic err);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.err = err;
        return e;
    endfunction

    // scoreboard check on every output handshake
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $error("FAIL sb_underflow: observed=%0h expected=nothing", out_quotient);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_q",   out_quotient,  e.q);
                chk("res_r",   out_remainder, e.r);
                chk("res_dz",  out_dz,        e.dz);
                chk("res_err", out_err,       e.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e,
                          input bit hold, input bit push);
        in_dividend = a; in_divisor = b; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready === 1'b1) begin
                if (push) sb.push_back(e);
                tick();
                if (!hold) in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (out_valid === 1'b1) return;
            tick();
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (busy === 1'b0) return;
            tick();
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int r0, s0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_div_rst", div_rst, 1);
        chk("rst_div_start", div_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dz", out_dz, 0);
        chk("rst_err", out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_q", out_quotient, 0);
        rst = 1'b0;
        tick();

        // 100/7 with cycle-level sequencing checks
        out_ready = 1'b1;
        r0 = n_rst; s0 = n_start;
        accept(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0, 1'b0), 1'b0, 1'b1);
        chk("n1_div_rst", div_rst, 1);
        chk("n1_div_start", div_start, 0);
        chk("n1_op_a", op_a, 100);
        tick();
        chk("n2_div_start", div_start, 1);
        chk("n2_div_rst", div_rst, 0);
        tick();
        for (int k = 0; k < 50 && div_done !== 1'b1; k++) tick();
        chk("done_pre_valid", out_valid, 0);
        tick();
        chk("done_valid", out_valid, 1);
        wait_idle("idle1_timeout");
        chk("rst_pulses", n_rst - r0, 1);
        chk("start_pulses", n_start - s0, 1);

        accept(16'd3, 16'd10, mk(16'd0, 16'd3, 1'b0, 1'b0), 1'b0, 1'b1);
        wait_out("out2_timeout");
        wait_idle("idle2_timeout");
        accept(16'hFFFF, 16'd1, mk(16'hFFFF, 16'd0, 1'b0, 1'b0), 1'b0, 1'b1);
        wait_out("out3_timeout");
        wait_idle("idle3_timeout");

        // divide by zero: immediate result, core untouched
        r0 = n_rst; s0 = n_start;
        accept(16'd5, 16'd0, mk(16'hFFFF, 16'd5, 1'b1, 1'b0), 1'b0, 1'b1);
        chk("dz_valid", out_valid, 1);
        chk("dz_flag", out_dz, 1);
        chk("dz_div_rst", div_rst, 0);
        wait_idle("idle_dz_timeout");
        chk("dz_rst_pulses", n_rst - r0, 0);
        chk("dz_start_pulses", n_start - s0, 0);

        // backpressure with in_valid held high
        out_ready = 1'b0;
        accept(16'd50, 16'd5, mk(16'd10, 16'd0, 1'b0, 1'b0), 1'b1, 1'b1);
        wait_out("bp_out_timeout");
        repeat (10) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_q", out_quotient, 10);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        sb.push_back(mk(16'd10, 16'd0, 1'b0, 1'b0));
        out_ready = 1'b1;
        tick();
        chk("bp_hs_in_ready", in_ready, 1);
        chk("bp_hs_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("bp_reaccept_busy", busy, 1);
        chk("bp_reaccept_rst", div_rst, 1);
        wait_out("bp2_out_timeout");
        wait_idle("bp2_idle_timeout");

        // watchdog: core never finishes
        hang = 1'b1;
        out_ready = 1'b0;
        accept(16'd7, 16'd2, mk(16'd0, 16'd0, 1'b0, 1'b1), 1'b0, 1'b1);
        tick();
        tick();
        repeat (TO - 1) tick();
        chk("wd_early_valid", out_valid, 0);
        tick();
        chk("wd_valid", out_valid, 1);
        chk("wd_err", out_err, 1);
        chk("wd_q", out_quotient, 0);
        out_ready = 1'b1;
        wait_idle("wd_idle_timeout");
        hang = 1'b0;
        accept(16'd9, 16'd3, mk(16'd3, 16'd0, 1'b0, 1'b0), 1'b0, 1'b1);
        wait_out("post_wd_timeout");
        wait_idle("post_wd_idle_timeout");

        // asynchronous reset two cycles into WAIT
        accept(16'd8, 16'd2, mk(16'd4, 16'd0, 1'b0, 1'b0), 1'b0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mr_div_rst", div_rst, 1);
        chk("mr_div_start", div_start, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_op_a", op_a, 0);
        chk("mr_op_b", op_b, 0);
        chk("mr_q", out_quotient, 0);
        chk("mr_r", out_remainder, 0);
        tick();
        rst = 1'b0;
        tick();
        stale_req = 1'b1;
        tick();
        stale_req = 1'b0;
        accept(16'd20, 16'd6, mk(16'd3, 16'd2, 1'b0, 1'b0), 1'b0, 1'b1);
        wait_out("mr_out_timeout");
        wait_idle("mr_idle_timeout");

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
